submodule_insertion_selector: RTL and testbench



---
 rtl/submodule_insertion_selector_if.sv | 25 ++
 rtl/submodule_insertion_selector.sv | 134 +++++++++++++
 tb/tb_submodule_insertion_selector.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/submodule_insertion_selector_if.sv
// Handshake bundle between the sorting logic (master) and the insertion selector (slave).
interface submodule_insertion_selector_if #(
    parameter int N  = 5,
    parameter int RW = 3
);
    logic          start;
    logic [N-1:0]  nums;
    logic [RW-1:0] r;
    logic          busy;
    logic          sel_valid;
    logic          sel_ready;
    logic [N-1:0]  sel_mask;
    logic [RW-1:0] sel_count;
    logic          short;

    modport master (
        output start, nums, r, sel_ready,
        input  busy, sel_valid, sel_mask, sel_count, short
    );

    modport slave (
        input  start, nums, r, sel_ready,
        output busy, sel_valid, sel_mask, sel_count, short
    );
endinterface

// File: rtl/submodule_insertion_selector.sv
// Builds an r-of-N insertion mask by scanning the eligibility vector one bit per clock.
// Optional macro ROTATE_PTR_EN: rotate the scan start pointer after each scan to spread insertion duty.
module submodule_insertion_selector #(
    parameter int N  = 5,
    parameter int RW = 3
) (
    input logic clk,
    input logic rst,
    submodule_insertion_selector_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_reg;
    logic [N-1:0]  nums_q_reg;
    logic [RW-1:0] r_q_reg;
    logic [N-1:0]  mask_reg;
    logic [RW-1:0] cnt_reg;
    logic [SW-1:0] steps_reg;
    logic [IW-1:0] idx_reg;
    logic          busy_reg;
    logic          sel_valid_reg;
    logic [N-1:0]  sel_mask_reg;
    logic [RW-1:0] sel_count_reg;
    logic          short_reg;

    logic [N-1:0]  hit_vec;
    logic [N-1:0]  mask_next;
    logic [RW-1:0] cnt_next;
    logic [SW-1:0] steps_next;
    logic [IW-1:0] idx_next;
    logic [IW-1:0] start_idx;
    logic [RW-1:0] r_clamped;
    logic          take;
    logic          scan_done;

`ifdef ROTATE_PTR_EN
    logic [IW-1:0] ptr_reg;
    assign start_idx = ptr_reg;
`else
    assign start_idx = '0;
`endif

    // One-hot decode of the bit under examination; avoids indexing past N with idx.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            assign hit_vec[gi]   = nums_q_reg[gi] && (idx_reg == IW'(gi));
            assign mask_next[gi] = mask_reg[gi] | (take && (idx_reg == IW'(gi)));
        end
    endgenerate

    assign take       = (|hit_vec) && (cnt_reg < r_q_reg);
    assign cnt_next   = cnt_reg + RW'(take);
    assign steps_next = steps_reg + SW'(1);
    assign idx_next   = (idx_reg == IW'(N - 1)) ? '0 : idx_reg + IW'(1);
    assign scan_done  = (cnt_next == r_q_reg) || (steps_next == SW'(N));
    assign r_clamped  = (int'(bus.r) > N) ? RW'(N) : bus.r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            nums_q_reg    <= '0;
            r_q_reg       <= '0;
            mask_reg      <= '0;
            cnt_reg       <= '0;
            steps_reg     <= '0;
            idx_reg       <= '0;
            busy_reg      <= 1'b0;
            sel_valid_reg <= 1'b0;
            sel_mask_reg  <= '0;
            sel_count_reg <= '0;
            short_reg     <= 1'b0;
`ifdef ROTATE_PTR_EN
            ptr_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        nums_q_reg <= bus.nums;
                        r_q_reg    <= r_clamped;
                        mask_reg   <= '0;
                        cnt_reg    <= '0;
                        steps_reg  <= '0;
                        idx_reg    <= start_idx;
                        busy_reg   <= 1'b1;
                        // Nothing to insert: publish an empty result without scanning.
                        if (r_clamped == '0) begin
                            state_reg     <= DONE;
                            sel_valid_reg <= 1'b1;
                            sel_mask_reg  <= '0;
                            sel_count_reg <= '0;
                            short_reg     <= 1'b0;
                        end else begin
                            state_reg <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    mask_reg  <= mask_next;
                    cnt_reg   <= cnt_next;
                    steps_reg <= steps_next;
                    idx_reg   <= idx_next;
                    if (scan_done) begin
                        state_reg     <= DONE;
                        sel_valid_reg <= 1'b1;
                        sel_mask_reg  <= mask_next;
                        sel_count_reg <= cnt_next;
                        short_reg     <= (cnt_next < r_q_reg);
`ifdef ROTATE_PTR_EN
                        ptr_reg       <= idx_next;
`endif
                    end
                end
                DONE: begin
                    if (bus.sel_ready) begin
                        state_reg     <= IDLE;
                        sel_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.sel_valid = sel_valid_reg;
    assign bus.sel_mask  = sel_mask_reg;
    assign bus.sel_count = sel_count_reg;
    assign bus.short     = short_reg;
endmodule

// File: tb/tb_submodule_insertion_selector.sv
// Directed bench for submodule_insertion_selector: per-cycle comparison against a latency/result model
// plus literal per-transaction expectations.
module tb_submodule_insertion_selector;
    localparam int N  = 5;
    localparam int RW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    submodule_insertion_selector_if #(.N(N), .RW(RW)) bus ();
    submodule_insertion_selector #(.N(N), .RW(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model state: what the outputs must be, derived from the scan rules.
    bit           m_busy, m_valid, m_short, p_short;
    logic [N-1:0] m_mask, p_mask;
    int           m_count, p_count, m_wait, m_ptr;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Walk the bits in scan order from ptr; stop once r (clamped) are taken or all N seen.
    function automatic void plan(input logic [N-1:0] nv, input int rv, input int pv,
                                 output logic [N-1:0] mk, output int ct, output bit sh,
                                 output int k, output int np);
        int rq;
        rq = (rv > N) ? N : rv;
        mk = '0; ct = 0; k = 0;
        for (int i = 0; i < N && ct < rq; i++) begin
            int j;
            j = (pv + i) % N;
            k = i + 1;
            if (nv[j]) begin
                mk[j] = 1'b1;
                ct++;
            end
        end
        sh = (ct < rq);
        np = (pv + k) % N;
    endfunction

    initial begin
        m_busy = 0; m_valid = 0; m_mask = '0; m_count = 0; m_short = 0; m_wait = 0; m_ptr = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 0; m_valid = 0; m_mask = '0; m_count = 0; m_short = 0; m_wait = 0; m_ptr = 0;
            end else if (!m_busy) begin
                if (bus.start) begin
                    int k, np;
                    plan(bus.nums, int'(bus.r), m_ptr, p_mask, p_count, p_short, k, np);
`ifdef ROTATE_PTR_EN
                    m_ptr = np;
`else
                    m_ptr = 0 * np;
`endif
                    m_busy = 1;
                    if (k == 0) begin
                        m_valid = 1; m_mask = '0; m_count = 0; m_short = 0;
                    end else begin
                        m_wait = k;
                    end
                end
            end else if (m_valid) begin
                if (bus.sel_ready) begin
                    m_valid = 0;
                    m_busy  = 0;
                end
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1; m_mask = p_mask; m_count = p_count; m_short = p_short;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy",      int'(bus.busy),      int'(m_busy));
                check("sel_valid", int'(bus.sel_valid), int'(m_valid));
                check("sel_mask",  int'(bus.sel_mask),  int'(m_mask));
                check("sel_count", int'(bus.sel_count), m_count);
                check("short",     int'(bus.short),     int'(m_short));
            end
        end
    end

    task automatic run(input string name, input logic [N-1:0] nv, input logic [RW-1:0] rv,
                       input logic [N-1:0] exp_mask, input int exp_count, input int exp_short,
                       input int exp_lat, input bit hold);
        int  lat;
        bit  got;
        @(negedge clk);
        bus.nums = nv; bus.r = rv; bus.start = 1'b1; bus.sel_ready = 1'b0;
        lat = 0; got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.sel_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_mask"},  int'(bus.sel_mask),  int'(exp_mask));
        check({name, "_count"}, int'(bus.sel_count), exp_count);
        check({name, "_short"}, int'(bus.short),     exp_short);
        $display("txn %s: nums=%b r=%0d mask=%b count=%0d short=%0d latency=%0d",
                 name, nv, rv, bus.sel_mask, bus.sel_count, bus.short, lat);
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                bus.nums  = ~bus.nums;
                bus.start = (c % 2 == 0);
                check({name, "_hold_valid"}, int'(bus.sel_valid), 1);
                check({name, "_hold_mask"},  int'(bus.sel_mask),  int'(exp_mask));
            end
            bus.start = 1'b0;
        end
        bus.sel_ready = 1'b1;
        @(negedge clk);
        bus.sel_ready = 1'b0;
        check({name, "_accept_valid"}, int'(bus.sel_valid), 0);
        check({name, "_accept_busy"},  int'(bus.busy),      0);
        check({name, "_kept_mask"},    int'(bus.sel_mask),  int'(exp_mask));
        @(negedge clk);
        check({name, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.nums = '0; bus.r = '0; bus.sel_ready = 1'b0;
        #1;
        check("reset_busy",  int'(bus.busy),      0);
        check("reset_valid", int'(bus.sel_valid), 0);
        check("reset_mask",  int'(bus.sel_mask),  0);
        check("reset_count", int'(bus.sel_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("t1_basic", 5'b10110, 3'd2, 5'b00110, 2, 0, 4, 0);
`ifdef ROTATE_PTR_EN
        run("t2_rotate", 5'b10110, 3'd2, 5'b10010, 2, 0, 5, 0);
`else
        run("t2_rotate", 5'b10110, 3'd2, 5'b00110, 2, 0, 4, 0);
`endif
        run("t3_short", 5'b00001, 3'd3, 5'b00001, 1, 1, 6, 0);
        run("t4_rzero", 5'b11111, 3'd0, 5'b00000, 0, 0, 1, 0);
        run("t5_clamp", 5'b11111, 3'd7, 5'b11111, 5, 0, 6, 0);
`ifdef ROTATE_PTR_EN
        run("t6_hold", 5'b10110, 3'd1, 5'b00100, 1, 0, 2, 1);
`else
        run("t6_hold", 5'b10110, 3'd1, 5'b00010, 1, 0, 3, 1);
`endif

        // Reset during the second SCAN cycle must clear outputs without a clock edge.
        @(negedge clk);
        bus.nums = 5'b11111; bus.r = 3'd5; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy",  int'(bus.busy),      0);
        check("midrst_valid", int'(bus.sel_valid), 0);
        check("midrst_mask",  int'(bus.sel_mask),  0);
        check("midrst_count", int'(bus.sel_count), 0);
        check("midrst_short", int'(bus.short),     0);
        $display("txn midrst: busy=%0d valid=%0d mask=%b", bus.busy, bus.sel_valid, bus.sel_mask);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("t8_after_rst", 5'b10110, 3'd2, 5'b00110, 2, 0, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
